// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - LSB-first serializer with valid/ready load and gapless back-to-back frames
// Optional feature macro: PARITY_EN (appends an even-parity bit after data bit N-1)

module parallel_to_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         ready,
  output logic         data_out,
  output logic         busy,
  output logic         done_tick
);

`ifdef PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   shift_reg;
  logic           last_bit;
  logic           accept;
  logic           next_bit;

`ifdef PARITY_EN
  logic           parity_reg;
  localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

  // after the last data bit the parity bit is the next one on the line
  always_comb begin
    next_bit = shift_reg[0];
    if (cnt == LAST_DATA) begin
      next_bit = parity_reg;
    end
  end

  // capture even parity of the accepted word alongside the shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^data_in;
    end
  end
`else
  assign next_bit = shift_reg[0];
`endif

  // ready and done_tick coincide on the final bit so a new word can follow with no gap
  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign ready     = (state == IDLE) || last_bit;
  assign done_tick = last_bit;
  assign accept    = load && ready;

  // frame FSM: loads a word, shifts it out one bit per clock, chains or returns to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      data_out  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            data_out  <= data_in[0];
            shift_reg <= data_in >> 1;
            cnt       <= '0;
          end else begin
            data_out  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            data_out  <= next_bit;
            shift_reg <= shift_reg >> 1;
            cnt       <= cnt + CW'(1);
          end else if (load) begin
            busy      <= 1'b1;
            data_out  <= data_in[0];
            shift_reg <= data_in >> 1;
            cnt       <= '0;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            data_out  <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          data_out <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed table-driven bench for parallel_to_serial (N=8)

module tb_parallel_to_serial;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       ready;
  logic       data_out;
  logic       busy;
  logic       done_tick;

  int checks;
  int failures;

  parallel_to_serial #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load      (load),
    .ready     (ready),
    .data_out  (data_out),
    .busy      (busy),
    .done_tick (done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       e_out;
    logic       e_busy;
    logic       e_ready;
    logic       e_done;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic o, input logic b, input logic r, input logic d);
    chk({tag, " data_out"}, {7'd0, data_out}, {7'd0, o});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, " ready"}, {7'd0, ready}, {7'd0, r});
    chk({tag, " done_tick"}, {7'd0, done_tick}, {7'd0, d});
  endtask

`ifndef PARITY_EN
  vec_t vt[37];

  function automatic vec_t mk(logic l, logic [7:0] d, logic o, logic b, logic r, logic dn);
    vec_t v;
    v.ld = l; v.din = d; v.e_out = o; v.e_busy = b; v.e_ready = r; v.e_done = dn;
    return v;
  endfunction
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    load     = 1'b0;
    data_in  = 8'h00;

    @(negedge clk);
    chk_outs("reset_state", 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // asynchronous reset in the middle of a frame
    load = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    load = 1'b0; data_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_outs("pre_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_outs("async_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_outs("post_reset_idle", 1'b0, 1'b0, 1'b1, 1'b0);

`ifndef PARITY_EN
    // single frame A5
    vt[0]  = mk(1, 8'hA5, 0, 0, 1, 0);
    vt[1]  = mk(0, 8'h00, 1, 1, 0, 0);
    vt[2]  = mk(0, 8'h00, 0, 1, 0, 0);
    vt[3]  = mk(0, 8'h00, 1, 1, 0, 0);
    vt[4]  = mk(0, 8'h00, 0, 1, 0, 0);
    vt[5]  = mk(0, 8'h00, 0, 1, 0, 0);
    vt[6]  = mk(0, 8'h00, 1, 1, 0, 0);
    vt[7]  = mk(0, 8'h00, 0, 1, 0, 0);
    vt[8]  = mk(0, 8'h00, 1, 1, 1, 1);
    // back-to-back 3C then F0
    vt[9]  = mk(1, 8'h3C, 0, 0, 1, 0);
    vt[10] = mk(1, 8'h3C, 0, 1, 0, 0);
    vt[11] = mk(1, 8'h3C, 0, 1, 0, 0);
    vt[12] = mk(1, 8'h3C, 1, 1, 0, 0);
    vt[13] = mk(1, 8'h3C, 1, 1, 0, 0);
    vt[14] = mk(1, 8'h3C, 1, 1, 0, 0);
    vt[15] = mk(1, 8'h3C, 1, 1, 0, 0);
    vt[16] = mk(1, 8'h3C, 0, 1, 0, 0);
    vt[17] = mk(1, 8'hF0, 0, 1, 1, 1);
    vt[18] = mk(1, 8'hF0, 0, 1, 0, 0);
    vt[19] = mk(1, 8'hF0, 0, 1, 0, 0);
    vt[20] = mk(1, 8'hF0, 0, 1, 0, 0);
    vt[21] = mk(1, 8'hF0, 0, 1, 0, 0);
    vt[22] = mk(1, 8'hF0, 1, 1, 0, 0);
    vt[23] = mk(1, 8'hF0, 1, 1, 0, 0);
    vt[24] = mk(1, 8'hF0, 1, 1, 0, 0);
    vt[25] = mk(0, 8'h00, 1, 1, 1, 1);
    // ignored load during bit 3 of an all-zero frame
    vt[26] = mk(1, 8'h00, 0, 0, 1, 0);
    vt[27] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[28] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[29] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[30] = mk(1, 8'hFF, 0, 1, 0, 0);
    vt[31] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[32] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[33] = mk(0, 8'h00, 0, 1, 0, 0);
    vt[34] = mk(0, 8'h00, 0, 1, 1, 1);
    vt[35] = mk(0, 8'h00, 0, 0, 1, 0);
    vt[36] = mk(0, 8'h00, 0, 0, 1, 0);

    for (int i = 0; i < 37; i++) begin
      chk_outs($sformatf("v%0d", i), vt[i].e_out, vt[i].e_busy, vt[i].e_ready, vt[i].e_done);
      load    = vt[i].ld;
      data_in = vt[i].din;
      @(negedge clk);
    end

    // loopback into a behavioural serial-to-parallel receiver, gapless 01, 80, 55
    begin
      logic [7:0] words [3];
      logic [7:0] s2p;
      int         sent;
      int         got;
      int         nbits;
      words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'h55;
      s2p   = 8'h00;
      got   = 0;
      nbits = 0;
      load    = 1'b1;
      data_in = words[0];
      sent    = 1;
      for (int c = 0; c < 40 && got < 3; c++) begin
        @(negedge clk);
        chk($sformatf("loop_busy c%0d", c), {7'd0, busy}, 8'h01);
        s2p = {data_out, s2p[7:1]};
        nbits++;
        if (done_tick) begin
          chk($sformatf("loop_word%0d", got), s2p, words[got]);
          got++;
        end
        if (ready && sent < 3) begin
          load    = 1'b1;
          data_in = words[sent];
          sent++;
        end else begin
          load    = 1'b0;
          data_in = 8'h00;
        end
      end
      chk("loop_words_received", 8'(got), 8'd3);
      chk("loop_bit_count", 8'(nbits), 8'd24);
      @(negedge clk);
      chk_outs("loop_end_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    end
`else
    // parity frames: 07 then 03 gapless
    begin
      logic [17:0] exp_bits;
      exp_bits = {9'b0_0000_0011, 9'b1_0000_0111};
      load    = 1'b1;
      data_in = 8'h07;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        chk_outs($sformatf("par%0d", i), exp_bits[i], 1'b1, (i == 8 || i == 17), (i == 8 || i == 17));
        if (i == 8) begin
          load    = 1'b1;
          data_in = 8'h03;
        end else begin
          load    = 1'b0;
          data_in = 8'h00;
        end
      end
      @(negedge clk);
      chk_outs("par_end_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
